uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 25 ++
 rtl/uart_rx_fifo.sv | 91 +++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - Frame-in / head-out handshake bundle for the UART receive FIFO.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  par_err;
  logic                  stp_err;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_par_err;
  logic                  out_stp_err;

  // master: receiver plus consumer; slave: the FIFO
  modport master (
    output data_valid, P_DATA, par_err, stp_err, out_ready,
    input  out_valid, out_data, out_par_err, out_stp_err
  );

  modport slave (
    input  data_valid, P_DATA, par_err, stp_err, out_ready,
    output out_valid, out_data, out_par_err, out_stp_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - First-word fall-through FIFO for received UART frames.
// Errored frames are dropped and counted, or stored with their error tags.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  uart_rx_fifo_if.slave            bus,
  input  logic                     drop_err_en,
  input  logic                     clr_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + 2;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic rd_en, wr_req, wr_en, drop;

  always_comb begin
    rd_en  = ~empty & bus.out_ready;
    drop   = bus.data_valid & (bus.par_err | bus.stp_err) & drop_err_en;
    wr_req = bus.data_valid & ~drop;
    // a full FIFO still accepts a frame when the head leaves in the same cycle
    wr_en  = wr_req & (~full | rd_en);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (wr_req && !wr_en) overflow_d = 1'b1;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // storage is left uninitialised; only the pointers define what is valid
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem_q[wr_ptr_q] <= {bus.P_DATA, bus.par_err, bus.stp_err};
  end

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  assign bus.out_valid = ~empty;
  assign {bus.out_data, bus.out_par_err, bus.out_stp_err} = mem_q[rd_ptr_q];
endmodule
